md_phase_sequencer: RTL and testbench

Generalised timestep controller for the MD pipeline. It sequences NUM_PHASES compute phases per timestep using per-phase ready/done handshakes, and rotates the position/velocity buffer select across NUM_BUFFERS banks. It counts completed timesteps against a programmable limit and signals completion. It sits between memory-init logic (mem_set) and the phase engines (cell-list, force, motion-update).

---
 rtl/md_seq_pkg.sv | 20 ++
 rtl/md_next_phase.sv | 48 ++++
 rtl/md_phase_sequencer.sv | 128 ++++++++++++
 tb/tb_md_phase_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_seq_pkg.sv
// Shared types and helpers for the MD timestep sequencer.
// State enum, index-width helper, default phase numbering.
package md_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int PH_CELL   = 0;
  localparam int PH_FORCE  = 1;
  localparam int PH_MOTION = 2;

  // Index width: max(1, clog2(n)).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/md_next_phase.sv
// Next-phase selector: maps current phase (plus optional skip
// mask, macro PHASE_SKIP_EN) to next/wrap/entry index and last flag.
// Ports: i_cur, [i_skip_mask], o_next, o_wrap, o_entry, o_last.
module md_next_phase
  import md_seq_pkg::*;
#(
  parameter int NUM_PHASES  = 3,
  parameter int START_PHASE = 0,
  parameter int PHASE_W     = idx_w(NUM_PHASES)
) (
  input  logic [PHASE_W-1:0]    i_cur,
`ifdef PHASE_SKIP_EN
  input  logic [NUM_PHASES-1:0] i_skip_mask,
`endif
  output logic [PHASE_W-1:0]    o_next,
  output logic [PHASE_W-1:0]    o_wrap,
  output logic [PHASE_W-1:0]    o_entry,
  output logic                  o_last
);

  localparam int LAST = NUM_PHASES - 1;

  assign o_last = (i_cur == PHASE_W'(LAST));

`ifdef PHASE_SKIP_EN
  // Lowest unmasked index >= base; last phase is never skipped.
  function automatic logic [PHASE_W-1:0] first_from(
    input int                  base,
    input logic [NUM_PHASES-1:0] m
  );
    logic [PHASE_W-1:0] r;
    r = PHASE_W'(LAST);
    for (int i = LAST - 1; i >= 0; i--) begin
      if (i >= base && !m[i]) r = PHASE_W'(i);
    end
    return r;
  endfunction

  assign o_next  = first_from(int'(i_cur) + 1, i_skip_mask);
  assign o_wrap  = first_from(0, i_skip_mask);
  assign o_entry = first_from(START_PHASE, i_skip_mask);
`else
  assign o_next  = i_cur + PHASE_W'(1);
  assign o_wrap  = '0;
  assign o_entry = PHASE_W'(START_PHASE);
`endif

endmodule

// File: rtl/md_phase_sequencer.sv
// Timestep controller: walks NUM_PHASES ready/done handshakes per
// step, rotates buffer_sel over NUM_BUFFERS banks, counts steps to
// a latched limit. Optional skip_mask input under PHASE_SKIP_EN.
// Ports: clk, reset_n, mem_set, num_steps, restart, phase_done,
//        phase_ready, phase_idx, buffer_sel, step_count, busy, sim_done.
module md_phase_sequencer
  import md_seq_pkg::*;
#(
  parameter  int NUM_PHASES  = 3,
  parameter  int NUM_BUFFERS = 2,
  parameter  int STEP_W      = 32,
  parameter  int START_PHASE = 0,
  localparam int PHASE_W     = idx_w(NUM_PHASES),
  localparam int BUF_W       = idx_w(NUM_BUFFERS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_set,
  input  logic [STEP_W-1:0]     num_steps,
  input  logic                  restart,
  input  logic [NUM_PHASES-1:0] phase_done,
`ifdef PHASE_SKIP_EN
  input  logic [NUM_PHASES-1:0] skip_mask,
`endif
  output logic [NUM_PHASES-1:0] phase_ready,
  output logic [PHASE_W-1:0]    phase_idx,
  output logic [BUF_W-1:0]      buffer_sel,
  output logic [STEP_W-1:0]     step_count,
  output logic                  busy,
  output logic                  sim_done
);

  state_t              r_state, w_state;
  logic [PHASE_W-1:0]  r_phase, w_phase;
  logic [BUF_W-1:0]    r_buf, w_buf;
  logic [STEP_W-1:0]   r_count, w_count;
  logic [STEP_W-1:0]   r_limit, w_limit;
  logic [STEP_W-1:0]   w_inc;
  logic                r_busy, r_done;
  logic [PHASE_W-1:0]  w_next, w_wrap, w_entry;
  logic                w_last;

  md_next_phase #(
    .NUM_PHASES  (NUM_PHASES),
    .START_PHASE (START_PHASE),
    .PHASE_W     (PHASE_W)
  ) u_next (
    .i_cur       (r_phase),
`ifdef PHASE_SKIP_EN
    .i_skip_mask (skip_mask),
`endif
    .o_next      (w_next),
    .o_wrap      (w_wrap),
    .o_entry     (w_entry),
    .o_last      (w_last)
  );

  // Saturating increment of the step counter.
  assign w_inc = (r_count == '1) ? r_count
                                 : r_count + STEP_W'(1);

  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_buf   = r_buf;
    w_count = r_count;
    w_limit = r_limit;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (mem_set &&
            (r_state == S_IDLE || restart)) begin
          w_limit = num_steps;
          w_count = '0;
          if (num_steps == '0) begin
            w_state = S_DONE;
          end else begin
            w_state = S_RUN;
            w_phase = w_entry;
          end
        end
      end
      S_RUN: begin
        if (mem_set && phase_done[r_phase]) begin
          if (!w_last) begin
            w_phase = w_next;
          end else begin
            w_count = w_inc;
            w_buf   = (r_buf == BUF_W'(NUM_BUFFERS - 1))
                    ? '0 : r_buf + BUF_W'(1);
            if (w_inc == r_limit) w_state = S_DONE;
            else                  w_phase = w_wrap;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_buf   <= '0;
      r_count <= '0;
      r_limit <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_buf   <= w_buf;
      r_count <= w_count;
      r_limit <= w_limit;
      r_busy  <= (w_state == S_RUN);
      r_done  <= (w_state == S_DONE);
    end
  end

  // Decoded from registers only: no input-to-output paths.
  assign phase_ready = (r_state == S_RUN)
                     ? (NUM_PHASES'(1) << r_phase) : '0;
  assign phase_idx   = (r_state == S_RUN) ? r_phase : '0;
  assign buffer_sel  = r_buf;
  assign step_count  = r_count;
  assign busy        = r_busy;
  assign sim_done    = r_done;

endmodule

// File: tb/tb_md_phase_sequencer.sv
// Self-checking bench for md_phase_sequencer (2- and 3-bank builds).
// Directed steps plus random stimulus against a behavioural model.
module tb_md_phase_sequencer;

  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_set;
  logic [31:0] num_steps;
  logic        restart;
  logic [2:0]  phase_done;
  logic [2:0]  skip_mask;

  logic [2:0]  phase_ready;
  logic [1:0]  phase_idx;
  logic [0:0]  buffer_sel;
  logic [31:0] step_count;
  logic        busy, sim_done;

  logic [2:0]  rdy3;
  logic [1:0]  idx3;
  logic [1:0]  buf3;
  logic [31:0] step3;
  logic        busy3, done3;

  always #5 clk = ~clk;

  md_phase_sequencer u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_set     (mem_set),
    .num_steps   (num_steps),
    .restart     (restart),
    .phase_done  (phase_done),
`ifdef PHASE_SKIP_EN
    .skip_mask   (skip_mask),
`endif
    .phase_ready (phase_ready),
    .phase_idx   (phase_idx),
    .buffer_sel  (buffer_sel),
    .step_count  (step_count),
    .busy        (busy),
    .sim_done    (sim_done)
  );

  md_phase_sequencer #(.NUM_BUFFERS(3)) u_dut3 (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_set     (mem_set),
    .num_steps   (num_steps),
    .restart     (restart),
    .phase_done  (phase_done),
`ifdef PHASE_SKIP_EN
    .skip_mask   (skip_mask),
`endif
    .phase_ready (rdy3),
    .phase_idx   (idx3),
    .buffer_sel  (buf3),
    .step_count  (step3),
    .busy        (busy3),
    .sim_done    (done3)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0 idle, 1 running, 2 finished.
  int          m_mode;
  int          m_phase;
  int          m_total;
  logic [31:0] m_step;
  logic [31:0] m_limit;

  logic [2:0]  seq[$];
  logic [2:0]  last_rdy;
  int          bseq2[$];
  int          bseq3[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int first_ok(input int b);
    for (int i = b; i < NP - 1; i++)
      if (!skip_mask[i]) return i;
    return NP - 1;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_phase = 0;
    m_total = 0;
    m_step  = 0;
    m_limit = 0;
  endtask

  task automatic model_start();
    m_limit = num_steps;
    m_step  = 0;
    if (num_steps == 0) m_mode = 2;
    else begin
      m_mode  = 1;
      m_phase = first_ok(0);
    end
  endtask

  task automatic model_clk();
    if (!mem_set) return;
    if (m_mode == 0) model_start();
    else if (m_mode == 2) begin
      if (restart) model_start();
    end else if (phase_done[m_phase]) begin
      if (m_phase < NP - 1) m_phase = first_ok(m_phase + 1);
      else begin
        m_total++;
        if (m_step != '1) m_step++;
        if (m_step == m_limit) m_mode = 2;
        else m_phase = first_ok(0);
      end
    end
  endtask

  task automatic check_all();
    chk("ready", 64'(phase_ready),
        (m_mode == 1) ? (64'd1 << m_phase) : 64'd0);
    chk("idx", 64'(phase_idx),
        (m_mode == 1) ? 64'(m_phase) : 64'd0);
    chk("buf", 64'(buffer_sel), 64'(m_total % 2));
    chk("step", 64'(step_count), 64'(m_step));
    chk("busy", 64'(busy), 64'(m_mode == 1));
    chk("done", 64'(sim_done), 64'(m_mode == 2));
    chk("buf3", 64'(buf3), 64'(m_total % 3));
    chk("step3", 64'(step3), 64'(m_step));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_clk();
    #1;
    check_all();
    if (phase_ready != 0 && phase_ready != last_rdy)
      seq.push_back(phase_ready);
    last_rdy = phase_ready;
    if (int'(buffer_sel) != bseq2[$])
      bseq2.push_back(int'(buffer_sel));
    if (int'(buf3) != bseq3[$])
      bseq3.push_back(int'(buf3));
  endtask

  // Engine: done one cycle after ready, then dropped.
  task automatic engine();
    if (phase_done == 0 && phase_ready != 0)
      phase_done = phase_ready;
    else
      phase_done = 0;
  endtask

  task automatic clear_rec();
    seq.delete();
    last_rdy = 0;
    bseq2 = '{0};
    bseq3 = '{0};
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    mem_set    = 1'b0;
    restart    = 1'b0;
    phase_done = 0;
    #1;
    model_reset();
    check_all();
    repeat (2) tick();
    reset_n = 1'b1;
    clear_rec();
  endtask

  task automatic run_until_done(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (sim_done) break;
      engine();
    end
    phase_done = 0;
    chk("timeout", 64'(sim_done), 64'd1);
  endtask

  logic [2:0] e1 [6];
  int         e2 [5];

  initial begin
    reset_n    = 1'b0;
    mem_set    = 1'b0;
    num_steps  = 0;
    restart    = 1'b0;
    phase_done = 0;
    skip_mask  = 0;
    clear_rec();
    #2;

    // Two steps, full handshake sequence.
    do_reset();
    mem_set   = 1'b1;
    num_steps = 2;
    run_until_done(60);
    e1 = '{3'b001, 3'b010, 3'b100,
           3'b001, 3'b010, 3'b100};
    chk("seq_len", 64'(seq.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk("seq", 64'(seq[i]), 64'(e1[i]));
    chk("bseq2_len", 64'(bseq2.size()), 64'd3);
    chk("bseq2_end", 64'(bseq2[2]), 64'd0);
    chk("step2", 64'(step_count), 64'd2);

    // Four steps on the 3-bank build.
    do_reset();
    mem_set   = 1'b1;
    num_steps = 4;
    run_until_done(100);
    e2 = '{0, 1, 2, 0, 1};
    chk("bseq3_len", 64'(bseq3.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("bseq3", 64'(bseq3[i]), 64'(e2[i]));

    // Zero limit, then restart for one step.
    do_reset();
    mem_set   = 1'b1;
    num_steps = 0;
    tick();
    chk("zero_done", 64'(sim_done), 64'd1);
    repeat (2) tick();
    chk("zero_nordy", 64'(seq.size()), 64'd0);
    num_steps = 1;
    restart   = 1'b1;
    tick();
    restart = 1'b0;
    run_until_done(30);
    chk("restart_step", 64'(step_count), 64'd1);
    chk("restart_seq", 64'(seq.size()), 64'd3);

    // mem_set dropped while phase 1 done is held.
    do_reset();
    mem_set   = 1'b1;
    num_steps = 5;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (phase_ready == 3'b010) break;
      engine();
    end
    chk("reach_ph1", 64'(phase_ready), 64'd2);
    mem_set    = 1'b0;
    phase_done = 3'b010;
    repeat (5) begin
      tick();
      chk("frozen", 64'(phase_ready), 64'd2);
    end
    mem_set = 1'b1;
    tick();
    chk("resume", 64'(phase_ready), 64'd4);
    phase_done = 0;

    // Inactive done ignored, then async reset mid phase 1.
    for (int i = 0; i < 20; i++) begin
      tick();
      if (phase_ready == 3'b001) break;
      engine();
    end
    phase_done = 3'b100;
    repeat (2) tick();
    chk("ignore", 64'(phase_ready), 64'd1);
    phase_done = 3'b001;
    tick();
    phase_done = 0;
    tick();
    chk("mid_ph1", 64'(phase_ready), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("rst_rdy", 64'(phase_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_step", 64'(step_count), 64'd0);
    do_reset();

    // Random stimulus against the model.
    for (int i = 0; i < 500; i++) begin
      mem_set    = ($urandom % 5) != 0;
      phase_done = 3'($urandom);
      restart    = ($urandom % 8) == 0;
      num_steps  = $urandom % 4;
`ifdef PHASE_SKIP_EN
      skip_mask  = 3'($urandom);
`endif
      tick();
    end
    restart    = 1'b0;
    phase_done = 0;

`ifdef PHASE_SKIP_EN
    skip_mask = 3'b010;
    do_reset();
    mem_set   = 1'b1;
    num_steps = 2;
    run_until_done(60);
    chk("skip_len", 64'(seq.size()), 64'd4);
    chk("skip0", 64'(seq[0]), 64'd1);
    chk("skip1", 64'(seq[1]), 64'd4);
    chk("skip2", 64'(seq[2]), 64'd1);
    chk("skip3", 64'(seq[3]), 64'd4);
    skip_mask = 3'b111;
    do_reset();
    mem_set   = 1'b1;
    num_steps = 1;
    run_until_done(30);
    chk("skipall_len", 64'(seq.size()), 64'd1);
    chk("skipall", 64'(seq[0]), 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
